multi_unit_issue: RTL and testbench

- Parametrised issue stage between register read and the functional units (branch, ALUs, complex ALU, load/store, future units).
- Issues one decoded instruction per cycle to one of FUNITS units over a one-hot enable.
- Per-unit REQ/ACK handshake for units marked as handshaked; unmarked units are always ready.
- A single-entry holding register parks an instruction whose target unit is not ready, and raises a congestion stall until the instruction drains. A saturating counter records congestion cycles.

---
 rtl/multi_unit_issue_pkg.sv | 31 +++
 rtl/multi_unit_issue_hold_register.sv | 28 ++
 rtl/multi_unit_issue.sv | 144 ++++++++++++++
 tb/tb_multi_unit_issue.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/multi_unit_issue_pkg.sv
// Processor control package: shared issue-stage types and functional-unit indices.
package multi_unit_issue_pkg;

  localparam int DATA_W    = 16;
  localparam int REGADDR_W = 4;
  localparam int MINOROP_W = 4;
  localparam int WBSRC_W   = 2;
  localparam int UNIT_W    = 5;

  localparam int UNIT_ALU0   = 0;
  localparam int UNIT_ALU1   = 1;
  localparam int UNIT_CALU   = 2;
  localparam int UNIT_LSU    = 3;
  localparam int UNIT_BRANCH = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } issue_state_t;

  typedef struct packed {
    logic [MINOROP_W-1:0] opcode;
    logic [WBSRC_W-1:0]   wbsrc;
    logic                 wben;
    logic [REGADDR_W-1:0] wbaddr;
    logic [DATA_W-1:0]    dataA;
    logic [DATA_W-1:0]    dataB;
    logic [UNIT_W-1:0]    unit;
  } issue_bundle_t;

endpackage

// File: rtl/multi_unit_issue_hold_register.sv
// Single-entry skid register that parks one issue bundle while its unit is busy.
module issue_hold_register
  import multi_unit_issue_pkg::*;
(
  input  logic          clk,
  input  logic          sync_rst,
  input  logic          load,
  input  logic          clear,
  input  issue_bundle_t d,
  output issue_bundle_t q,
  output logic          valid
);

  // Entry storage; clear takes priority over load.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (load) begin
      q     <= d;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/multi_unit_issue.sv
// Issue stage: routes one decoded instruction per cycle to a functional unit,
// parking it in a skid register when a handshaked unit is not ready.
module multi_unit_issue
  import multi_unit_issue_pkg::*;
#(
  parameter int DATABITWIDTH    = DATA_W,
  parameter int REGADDRBITWIDTH = REGADDR_W,
  parameter int FUNITS          = UNIT_W,
  parameter int MINOROPBITWIDTH = MINOROP_W,
  parameter int WBSRCBITWIDTH   = WBSRC_W,
  parameter logic [FUNITS-1:0] HANDSHAKE_MASK = 5'b01000,
  parameter int PERFCNTBITWIDTH = 16
) (
  input  logic                       clk,
  input  logic                       clk_en,
  input  logic                       sync_rst,
  input  logic                       StallIn,
  input  logic [FUNITS-1:0]          FunctionalUnitEnable,
  input  logic [MINOROPBITWIDTH-1:0] MinorOpcode,
  input  logic [WBSRCBITWIDTH-1:0]   WriteBackSourceIn,
  input  logic                       WritebackEnIn,
  input  logic [REGADDRBITWIDTH-1:0] WritebackRegAddr,
  input  logic [DATABITWIDTH-1:0]    RegADataIn,
  input  logic [DATABITWIDTH-1:0]    RegBDataIn,
  input  logic [FUNITS-1:0]          Unit_REQ,
  output logic [FUNITS-1:0]          Unit_ACK,
  output logic [MINOROPBITWIDTH-1:0] Unit_MinorOpcode,
  output logic [DATABITWIDTH-1:0]    Data_A,
  output logic [DATABITWIDTH-1:0]    Data_B,
  output logic                       RegWriteEn,
  output logic [WBSRCBITWIDTH-1:0]   WriteBackSourceOut,
  output logic [REGADDRBITWIDTH-1:0] RegWriteAddrOut,
  output logic                       IssueCongestionStallOut,
  output logic                       MultiHotError,
  output logic [PERFCNTBITWIDTH-1:0] CongestionCycles
);

  localparam logic [FUNITS-1:0] ONE = {{(FUNITS-1){1'b0}}, 1'b1};

  issue_state_t stateR, stateNext;
  issue_bundle_t liveS, holdQ, srcS;
  logic [FUNITS-1:0] readyS, enLowS, srcUnitS, ackS;
  logic multiHotS, goS, srcReadyS, loadS, clearS, stallS, multiHotErrR;
  logic [PERFCNTBITWIDTH-1:0] congCntR;

  // Lowest set bit wins on a multi-hot enable.
  assign enLowS    = FunctionalUnitEnable & (~FunctionalUnitEnable + ONE);
  assign multiHotS = |(FunctionalUnitEnable & (FunctionalUnitEnable - ONE));
  assign readyS    = ~HANDSHAKE_MASK | Unit_REQ;
  assign goS       = ~StallIn & clk_en;

  assign liveS.opcode = MINOROP_W'(MinorOpcode);
  assign liveS.wbsrc  = WBSRC_W'(WriteBackSourceIn);
  assign liveS.wben   = WritebackEnIn;
  assign liveS.wbaddr = REGADDR_W'(WritebackRegAddr);
  assign liveS.dataA  = DATA_W'(RegADataIn);
  assign liveS.dataB  = DATA_W'(RegBDataIn);
  assign liveS.unit   = UNIT_W'(enLowS);

  assign srcS      = (stateR == HOLD) ? holdQ : liveS;
  assign srcUnitS  = FUNITS'(srcS.unit);
  assign srcReadyS = |(srcUnitS & readyS);

  issue_hold_register uHold (
    .clk      (clk),
    .sync_rst (sync_rst),
    .load     (loadS),
    .clear    (clearS),
    .d        (liveS),
    .q        (holdQ),
    .valid    ()
  );

  // Next-state, issue strobe and congestion stall.
  always_comb begin
    stateNext = stateR;
    ackS      = '0;
    loadS     = 1'b0;
    clearS    = 1'b0;
    stallS    = 1'b0;
    case (stateR)
      IDLE: begin
        if (goS && (|srcUnitS)) begin
          if (srcReadyS) begin
            ackS = srcUnitS;
          end else begin
            loadS     = 1'b1;
            stateNext = HOLD;
          end
        end else begin
          stateNext = IDLE;
        end
      end
      HOLD: begin
        if (goS && srcReadyS) begin
          ackS      = srcUnitS;
          clearS    = 1'b1;
          stateNext = IDLE;
        end else begin
          stallS = 1'b1;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      stateR <= IDLE;
    end else if (clk_en) begin
      stateR <= stateNext;
    end
  end

  // Sticky multi-hot flag and saturating congestion counter.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      multiHotErrR <= 1'b0;
      congCntR     <= '0;
    end else if (clk_en) begin
      if (multiHotS && (stateR == IDLE)) begin
        multiHotErrR <= 1'b1;
      end
      if (stallS && !(&congCntR)) begin
        congCntR <= congCntR + PERFCNTBITWIDTH'(1);
      end
    end
  end

  assign Unit_ACK                = ackS;
  assign Unit_MinorOpcode        = MINOROPBITWIDTH'(srcS.opcode);
  assign Data_A                  = DATABITWIDTH'(srcS.dataA);
  assign Data_B                  = DATABITWIDTH'(srcS.dataB);
  assign RegWriteEn              = srcS.wben & (|ackS);
  assign WriteBackSourceOut      = WBSRCBITWIDTH'(srcS.wbsrc);
  assign RegWriteAddrOut         = REGADDRBITWIDTH'(srcS.wbaddr);
  assign IssueCongestionStallOut = stallS;
  assign MultiHotError           = multiHotErrR;
  assign CongestionCycles        = congCntR;

endmodule

// File: tb/tb_multi_unit_issue.sv
// Self-checking bench for multi_unit_issue: vector table plus scoreboarded hold/drain sequences.
module tb_multi_unit_issue;

  logic        clk = 1'b0;
  logic        clk_en, sync_rst, StallIn;
  logic [4:0]  FunctionalUnitEnable, Unit_REQ, Unit_ACK;
  logic [3:0]  MinorOpcode, Unit_MinorOpcode;
  logic [1:0]  WriteBackSourceIn, WriteBackSourceOut;
  logic        WritebackEnIn, RegWriteEn, IssueCongestionStallOut, MultiHotError;
  logic [3:0]  WritebackRegAddr, RegWriteAddrOut;
  logic [15:0] RegADataIn, RegBDataIn, Data_A, Data_B, CongestionCycles;

  multi_unit_issue dut (
    .clk(clk), .clk_en(clk_en), .sync_rst(sync_rst), .StallIn(StallIn),
    .FunctionalUnitEnable(FunctionalUnitEnable), .MinorOpcode(MinorOpcode),
    .WriteBackSourceIn(WriteBackSourceIn), .WritebackEnIn(WritebackEnIn),
    .WritebackRegAddr(WritebackRegAddr), .RegADataIn(RegADataIn), .RegBDataIn(RegBDataIn),
    .Unit_REQ(Unit_REQ), .Unit_ACK(Unit_ACK), .Unit_MinorOpcode(Unit_MinorOpcode),
    .Data_A(Data_A), .Data_B(Data_B), .RegWriteEn(RegWriteEn),
    .WriteBackSourceOut(WriteBackSourceOut), .RegWriteAddrOut(RegWriteAddrOut),
    .IssueCongestionStallOut(IssueCongestionStallOut), .MultiHotError(MultiHotError),
    .CongestionCycles(CongestionCycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  en;
    logic [4:0]  req;
    logic        stl;
    logic        cke;
    logic [15:0] a;
    logic        wben;
    logic [4:0]  expAck;
    logic        expRwe;
  } vec_t;

  typedef struct {
    logic [4:0]  unit;
    logic [3:0]  addr;
    logic [15:0] a;
  } exp_t;

  vec_t vecs[9];
  exp_t sbq[$];
  exp_t e;
  int   passCnt = 0;
  int   totalCnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [4:0] en, input logic [4:0] req, input logic stl,
                     input logic cke, input logic [15:0] a, input logic [3:0] addr,
                     input logic wben);
    FunctionalUnitEnable = en;
    Unit_REQ             = req;
    StallIn              = stl;
    clk_en               = cke;
    RegADataIn           = a;
    RegBDataIn           = ~a;
    MinorOpcode          = a[3:0];
    WriteBackSourceIn    = 2'b01;
    WritebackRegAddr     = addr;
    WritebackEnIn        = wben;
  endtask

  // Scoreboard: every observed issue strobe must match the oldest expected issue.
  always @(negedge clk) begin
    if (!sync_rst && Unit_ACK != 5'b0) begin
      if (sbq.size() == 0) begin
        chk("unexpectedAck", {27'b0, Unit_ACK}, 32'h0);
      end else begin
        e = sbq.pop_front();
        chk("sbUnit", {27'b0, Unit_ACK}, {27'b0, e.unit});
        chk("sbAddr", {28'b0, RegWriteAddrOut}, {28'b0, e.addr});
        chk("sbDataA", {16'b0, Data_A}, {16'b0, e.a});
      end
    end
  end

  initial begin
    vecs[0] = '{5'b00001, 5'b00000, 1'b0, 1'b1, 16'h1234, 1'b1, 5'b00001, 1'b1};
    vecs[1] = '{5'b00010, 5'b00000, 1'b0, 1'b1, 16'hBEEF, 1'b1, 5'b00010, 1'b1};
    vecs[2] = '{5'b00100, 5'b00000, 1'b0, 1'b1, 16'h00C3, 1'b0, 5'b00100, 1'b0};
    vecs[3] = '{5'b10000, 5'b00000, 1'b0, 1'b1, 16'h4242, 1'b1, 5'b10000, 1'b1};
    vecs[4] = '{5'b00000, 5'b00000, 1'b0, 1'b1, 16'h9999, 1'b1, 5'b00000, 1'b0};
    vecs[5] = '{5'b00001, 5'b00000, 1'b1, 1'b1, 16'h3333, 1'b1, 5'b00000, 1'b0};
    vecs[6] = '{5'b01000, 5'b01000, 1'b0, 1'b1, 16'h2468, 1'b1, 5'b01000, 1'b1};
    vecs[7] = '{5'b01000, 5'b00000, 1'b1, 1'b1, 16'h1357, 1'b1, 5'b00000, 1'b0};
    vecs[8] = '{5'b00001, 5'b00000, 1'b0, 1'b0, 16'hFACE, 1'b1, 5'b00000, 1'b0};

    drv(5'b0, 5'b0, 1'b0, 1'b1, 16'h0, 4'h0, 1'b0);
    sync_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 sync_rst = 1'b0;
    @(negedge clk);
    chk("rstAck", {27'b0, Unit_ACK}, 32'h0);
    chk("rstStall", {31'b0, IssueCongestionStallOut}, 32'h0);
    chk("rstMhe", {31'b0, MultiHotError}, 32'h0);
    chk("rstCnt", {16'b0, CongestionCycles}, 32'h0);
    chk("rstRwe", {31'b0, RegWriteEn}, 32'h0);

    for (int i = 0; i < 9; i++) begin
      nxt();
      drv(vecs[i].en, vecs[i].req, vecs[i].stl, vecs[i].cke, vecs[i].a, 4'(i), vecs[i].wben);
      if (vecs[i].expAck != 5'b0) sbq.push_back('{vecs[i].expAck, 4'(i), vecs[i].a});
      @(negedge clk);
      chk($sformatf("vecAck%0d", i), {27'b0, Unit_ACK}, {27'b0, vecs[i].expAck});
      chk($sformatf("vecRwe%0d", i), {31'b0, RegWriteEn}, {31'b0, vecs[i].expRwe});
      chk($sformatf("vecDataB%0d", i), {16'b0, Data_B}, {16'b0, ~vecs[i].a});
      chk($sformatf("vecStall%0d", i), {31'b0, IssueCongestionStallOut}, 32'h0);
    end
    chk("tableCnt", {16'b0, CongestionCycles}, 32'h0);

    // LSU not ready for three cycles, then drains.
    nxt(); drv(5'b01000, 5'b0, 1'b0, 1'b1, 16'h5555, 4'h7, 1'b1);
    sbq.push_back('{5'b01000, 4'h7, 16'h5555});
    @(negedge clk);
    chk("capAck", {27'b0, Unit_ACK}, 32'h0);
    chk("capStall", {31'b0, IssueCongestionStallOut}, 32'h0);
    nxt(); drv(5'b00001, 5'b0, 1'b0, 1'b1, 16'hAAAA, 4'h1, 1'b1);
    @(negedge clk);
    chk("hold1Stall", {31'b0, IssueCongestionStallOut}, 32'h1);
    chk("hold1Ack", {27'b0, Unit_ACK}, 32'h0);
    chk("hold1DataA", {16'b0, Data_A}, 32'h5555);
    nxt(); @(negedge clk);
    chk("hold2Stall", {31'b0, IssueCongestionStallOut}, 32'h1);
    nxt(); Unit_REQ = 5'b01000; @(negedge clk);
    chk("drainAck", {27'b0, Unit_ACK}, 32'h8);
    chk("drainAddr", {28'b0, RegWriteAddrOut}, 32'h7);
    chk("drainStall", {31'b0, IssueCongestionStallOut}, 32'h0);
    chk("drainRwe", {31'b0, RegWriteEn}, 32'h1);
    nxt(); drv(5'b0, 5'b0, 1'b0, 1'b1, 16'h0, 4'h0, 1'b0); @(negedge clk);
    chk("drainCnt", {16'b0, CongestionCycles}, 32'h2);

    // Held LSU ready but downstream stalled for two cycles.
    nxt(); drv(5'b01000, 5'b0, 1'b0, 1'b1, 16'h6666, 4'h9, 1'b1);
    sbq.push_back('{5'b01000, 4'h9, 16'h6666});
    @(negedge clk);
    nxt(); drv(5'b0, 5'b01000, 1'b1, 1'b1, 16'h0, 4'h0, 1'b0); @(negedge clk);
    chk("stl1Ack", {27'b0, Unit_ACK}, 32'h0);
    chk("stl1Stall", {31'b0, IssueCongestionStallOut}, 32'h1);
    nxt(); @(negedge clk);
    chk("stl2Ack", {27'b0, Unit_ACK}, 32'h0);
    nxt(); StallIn = 1'b0; @(negedge clk);
    chk("stlRelAck", {27'b0, Unit_ACK}, 32'h8);
    chk("stlRelStall", {31'b0, IssueCongestionStallOut}, 32'h0);
    nxt(); drv(5'b0, 5'b0, 1'b0, 1'b1, 16'h0, 4'h0, 1'b0); @(negedge clk);
    chk("stlCnt", {16'b0, CongestionCycles}, 32'h4);

    // Multi-hot enable: lowest index issues, sticky error from next cycle.
    nxt(); drv(5'b00011, 5'b0, 1'b0, 1'b1, 16'h0F0F, 4'h2, 1'b1);
    sbq.push_back('{5'b00001, 4'h2, 16'h0F0F});
    @(negedge clk);
    chk("mhAck", {27'b0, Unit_ACK}, 32'h1);
    chk("mheNotYet", {31'b0, MultiHotError}, 32'h0);
    nxt(); drv(5'b00010, 5'b0, 1'b0, 1'b1, 16'h1111, 4'h3, 1'b1);
    sbq.push_back('{5'b00010, 4'h3, 16'h1111});
    @(negedge clk);
    chk("mheSet", {31'b0, MultiHotError}, 32'h1);
    nxt(); drv(5'b0, 5'b0, 1'b0, 1'b1, 16'h0, 4'h0, 1'b0); @(negedge clk);
    chk("mheSticky", {31'b0, MultiHotError}, 32'h1);

    // clk_en low while held LSU is ready.
    nxt(); drv(5'b01000, 5'b0, 1'b0, 1'b1, 16'h7777, 4'hA, 1'b1);
    sbq.push_back('{5'b01000, 4'hA, 16'h7777});
    @(negedge clk);
    nxt(); drv(5'b0, 5'b01000, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0); @(negedge clk);
    chk("ckeAck", {27'b0, Unit_ACK}, 32'h0);
    chk("ckeStall", {31'b0, IssueCongestionStallOut}, 32'h1);
    nxt(); @(negedge clk);
    chk("ckeCnt", {16'b0, CongestionCycles}, 32'h4);
    nxt(); clk_en = 1'b1; @(negedge clk);
    chk("ckeRelAck", {27'b0, Unit_ACK}, 32'h8);
    chk("ckeRelStall", {31'b0, IssueCongestionStallOut}, 32'h0);
    nxt(); drv(5'b0, 5'b0, 1'b0, 1'b1, 16'h0, 4'h0, 1'b0); @(negedge clk);
    chk("ckeCntAfter", {16'b0, CongestionCycles}, 32'h4);

    // Reset while holding drops the instruction.
    nxt(); drv(5'b01000, 5'b0, 1'b0, 1'b1, 16'h8888, 4'hB, 1'b1); @(negedge clk);
    chk("rhCapAck", {27'b0, Unit_ACK}, 32'h0);
    nxt(); drv(5'b0, 5'b0, 1'b0, 1'b1, 16'h0, 4'h0, 1'b0); @(negedge clk);
    chk("rhStall", {31'b0, IssueCongestionStallOut}, 32'h1);
    nxt(); sync_rst = 1'b1; @(negedge clk);
    nxt(); sync_rst = 1'b0; Unit_REQ = 5'b01000; @(negedge clk);
    chk("rhAck", {27'b0, Unit_ACK}, 32'h0);
    chk("rhStall0", {31'b0, IssueCongestionStallOut}, 32'h0);
    chk("rhCnt", {16'b0, CongestionCycles}, 32'h0);
    chk("rhMhe", {31'b0, MultiHotError}, 32'h0);
    nxt(); @(negedge clk);
    chk("rhAckLater", {27'b0, Unit_ACK}, 32'h0);

    chk("sbEmpty", sbq.size(), 32'h0);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
